// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the pipeline and a data memory
// with one registered read port and a memory-mapped LED register.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only when idle)
//   req_is_store, req_funct3         access kind and RV32I width/sign code
//   req_addr, req_wdata              byte address and right-aligned store data
//   mem_addr, mem_wdata              latched address/data to data memory
//   mem_memread, mem_memwrite        one-cycle strobes, only in ISSUE
//   mem_sign_mask                    {signed, word, half-or-word, 1}
//   mem_read_data                    registered load result from memory
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               load result (0 for stores/errors), error flag
module lsu_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_1000,
  parameter int unsigned DMEM_BYTES = 4096,
  parameter logic [31:0] LED_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned EW = 33;
  localparam logic [EW-1:0] DMEM_END = EW'(DMEM_BASE) + EW'(DMEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_LATCH,
    S_RESP
  } state_e;

  state_e      state;
  state_e      state_nxt;
  logic        is_store_q;
  logic        accept_c;
  logic        req_err_c;
  logic [3:0]  mask_c;
  logic        f3_bad_c;
  logic        misalign_c;
  logic        in_dmem_c;
  logic        range_bad_c;
  logic [2:0]  size_c;

  assign accept_c = req_valid & req_ready;

  // Request legality: funct3, alignment and address decode.
  always_comb begin
    f3_bad_c    = 1'b0;
    misalign_c  = 1'b0;
    in_dmem_c   = 1'b0;
    range_bad_c = 1'b0;
    if (req_is_store) begin
      f3_bad_c = (req_funct3 >= 3'b011);
    end else begin
      f3_bad_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    in_dmem_c  = (req_addr >= DMEM_BASE) && ({1'b0, req_addr} < DMEM_END);
    // LED register is write-only and lives outside the data memory window.
    range_bad_c = (req_addr == LED_ADDR) ? !req_is_store : !in_dmem_c;
    req_err_c   = f3_bad_c | misalign_c | range_bad_c;
  end

  // Access encoding for the memory: size bits plus sign for LB/LH.
  always_comb begin
    size_c = 3'b111;
    case (req_funct3[1:0])
      2'b00:   size_c = 3'b001;
      2'b01:   size_c = 3'b011;
      default: size_c = 3'b111;
    endcase
    mask_c = {!req_is_store && !req_funct3[2] && (req_funct3[1:0] != 2'b10), size_c};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = req_err_c ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b1;
      is_store_q    <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_sign_mask <= '0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      req_ready <= (state_nxt == S_IDLE);
      // ISSUE is only entered from an accept, so the live request decides the strobe.
      mem_memread  <= (state_nxt == S_ISSUE) && !req_is_store;
      mem_memwrite <= (state_nxt == S_ISSUE) && req_is_store;
      rsp_valid    <= (state_nxt == S_RESP);
      if (accept_c) begin
        is_store_q    <= req_is_store;
        mem_addr      <= req_addr;
        mem_wdata     <= req_wdata;
        mem_sign_mask <= mask_c;
        if (req_err_c) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (state == S_LATCH) begin
        rsp_rdata <= is_store_q ? 32'h0 : mem_read_data;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed table, corner sequences, random traffic.
module tb_lsu_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          BYTES = 4096;
  localparam logic [31:0] LED   = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DMEM_BASE(BASE), .DMEM_BYTES(BYTES), .LED_ADDR(LED)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // ---------------- data memory + LED model (environment) ----------------
  logic [7:0] dmem [BYTES];
  logic [7:0] led;
  bit         mem_inited;

  function automatic logic [7:0] init_byte(int i);
    case (i)
      3: return 8'h80;
      4: return 8'hEF;
      5: return 8'hBE;
      6: return 8'hAD;
      7: return 8'hDE;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  function automatic logic [31:0] mem_load(logic [31:0] a, logic [3:0] m);
    int idx = int'(a - BASE);
    int n = m[2] ? 4 : (m[1] ? 2 : 1);
    logic [31:0] v = 32'h0;
    for (int k = n - 1; k >= 0; k--)
      v = (v << 8) | ((idx + k >= 0 && idx + k < BYTES) ? 32'(dmem[idx + k]) : 32'h0);
    if (m[3] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < BYTES; i++) dmem[i] <= init_byte(i);
      mem_inited <= 1'b1;
      led <= 8'h00;
    end
    if (mem_memread) mem_read_data <= mem_load(mem_addr, mem_sign_mask);
    if (mem_memwrite) begin
      if (mem_addr == LED) led <= mem_wdata[7:0];
      else begin
        for (int k = 0; k < 4; k++) begin
          if ((k == 0 || (k == 1 && mem_sign_mask[1]) || mem_sign_mask[2]) &&
              int'(mem_addr - BASE) + k >= 0 && int'(mem_addr - BASE) + k < BYTES)
            dmem[int'(mem_addr - BASE) + k] <= 8'(mem_wdata >> (8 * k));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [BYTES];

  function automatic int acc_size(logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic ref_err(logic st, logic [2:0] f3, logic [31:0] a);
    bit legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if ((a & 32'(acc_size(f3) - 1)) != 32'h0) return 1'b1;
    if (a == LED) return !st;
    if (longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + longint'(BYTES)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    int n = acc_size(f3);
    longint val = 0;
    for (int k = 0; k < n; k++) val = val + (longint'(ref_mem[int'(a - BASE) + k]) << (8 * k));
    if (!f3[2] && n < 4 && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
    return 32'(val);
  endfunction

  function automatic void ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    if (a == LED) return;
    for (int k = 0; k < acc_size(f3); k++) ref_mem[int'(a - BASE) + k] = 8'(wd >> (8 * k));
  endfunction

  function automatic logic [3:0] ref_mask(logic st, logic [2:0] f3);
    int n = acc_size(f3);
    logic sgn = !st && (f3 == 3'd0 || f3 == 3'd1);
    return {sgn, n == 4, n >= 2, 1'b1};
  endfunction

  // ---------------- checking helpers ----------------
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void chk_reset(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_memread"}, 32'(mem_memread), 32'd0);
    chk({tag, "_memwrite"}, 32'(mem_memwrite), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mask"}, 32'(mem_sign_mask), 32'd0);
  endfunction

  // One full transaction; edges counted include the accept edge.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                         input logic [3:0] exp_mask, input int hold);
    int edges = 1;
    int nrd = 0;
    int nwr = 0;
    logic [31:0] rd0;
    logic e0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    rsp_ready = (hold == 0);
    forever begin
      if (mem_memread) nrd++;
      if (mem_memwrite) nwr++;
      if (mem_memread || mem_memwrite) begin
        chk("strobe_mask", 32'(mem_sign_mask), 32'(exp_mask));
        chk("strobe_addr", mem_addr, a);
        if (st) chk("strobe_wdata", mem_wdata, wd);
      end
      if (rsp_valid || edges >= 12) break;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk("latency", 32'(edges), exp_err ? 32'd1 : 32'd4);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("resp_req_ready", 32'(req_ready), 32'd0);
    chk("read_strobes", 32'(nrd), (!exp_err && !st) ? 32'd1 : 32'd0);
    chk("write_strobes", 32'(nwr), (!exp_err && st) ? 32'd1 : 32'd0);
    rd0 = rsp_rdata;
    e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, rd0);
      chk("hold_err", 32'(rsp_err), 32'(e0));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    if (st && !exp_err && a == LED) chk("led", 32'(led), 32'(wd[7:0]));
  endtask

  // Reset pulse while a load is in ISSUE (stage 0) or WAIT (stage 1).
  task automatic abort_txn(input int stage);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1004;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (stage == 0) chk("abort_strobe_before", 32'(mem_memread), 32'd1);
    for (int i = 0; i < stage; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
    logic err; logic [31:0] rd; logic [3:0] mask; int hold;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic e;
    logic [31:0] rd;
    int n;
    logic [2:0] ld_codes [5];

    for (int i = 0; i < BYTES; i++) ref_mem[i] = init_byte(i);
    ld_codes[0] = 3'd0; ld_codes[1] = 3'd1; ld_codes[2] = 3'd2; ld_codes[3] = 3'd4; ld_codes[4] = 3'd5;

    vecs[0]  = '{1'b0, 3'd2, 32'h1004, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0111, 0};
    vecs[1]  = '{1'b0, 3'd0, 32'h1003, 32'h0,        1'b0, 32'hFFFFFF80, 4'b1001, 1};
    vecs[2]  = '{1'b0, 3'd4, 32'h1003, 32'h0,        1'b0, 32'h00000080, 4'b0001, 0};
    vecs[3]  = '{1'b1, 3'd1, 32'h1001, 32'h1234,     1'b1, 32'h0,        4'b0000, 2};
    vecs[4]  = '{1'b0, 3'd2, 32'h3000, 32'h0,        1'b1, 32'h0,        4'b0000, 0};
    vecs[5]  = '{1'b0, 3'd3, 32'h1004, 32'h0,        1'b1, 32'h0,        4'b0000, 1};
    vecs[6]  = '{1'b1, 3'd2, 32'h2000, 32'h000000A5, 1'b0, 32'h0,        4'b0111, 3};
    vecs[7]  = '{1'b0, 3'd2, 32'h2000, 32'h0,        1'b1, 32'h0,        4'b0000, 0};
    vecs[8]  = '{1'b1, 3'd2, 32'h1008, 32'h87654321, 1'b0, 32'h0,        4'b0111, 0};
    vecs[9]  = '{1'b0, 3'd1, 32'h100A, 32'h0,        1'b0, 32'hFFFF8765, 4'b1011, 0};
    vecs[10] = '{1'b0, 3'd5, 32'h100A, 32'h0,        1'b0, 32'h00008765, 4'b0011, 1};
    vecs[11] = '{1'b0, 3'd0, 32'h1008, 32'h0,        1'b0, 32'h00000021, 4'b1001, 0};
    vecs[12] = '{1'b1, 3'd0, 32'h1FFF, 32'h000001FF, 1'b0, 32'h0,        4'b0001, 0};
    vecs[13] = '{1'b0, 3'd4, 32'h1FFF, 32'h0,        1'b0, 32'h000000FF, 4'b0001, 0};
    vecs[14] = '{1'b0, 3'd2, 32'h1000, 32'h0,        1'b0, 32'h804F2A05, 4'b0111, 0};
    vecs[15] = '{1'b0, 3'd0, 32'h0FFF, 32'h0,        1'b1, 32'h0,        4'b0000, 0};
    vecs[16] = '{1'b0, 3'd2, 32'h1002, 32'h0,        1'b1, 32'h0,        4'b0000, 0};
    vecs[17] = '{1'b1, 3'd3, 32'h1000, 32'h0,        1'b1, 32'h0,        4'b0000, 0};
    vecs[18] = '{1'b0, 3'd2, 32'h1FFC, 32'h0,        1'b0, 32'hFFBB9671, 4'b0111, 2};
    vecs[19] = '{1'b1, 3'd0, 32'h2000, 32'h0000005A, 1'b0, 32'h0,        4'b0001, 0};

    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      run_txn(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].err, vecs[i].rd,
              vecs[i].mask, vecs[i].hold);
      if (vecs[i].st && !vecs[i].err) ref_store(vecs[i].f3, vecs[i].a, vecs[i].wd);
    end

    // Second request held during a stalled response is taken only after RESP exits.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1004;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h1008;
    n = 1;
    while (!rsp_valid && n < 12) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", 32'(n), 32'd4);
    chk("b2b_addr_held", mem_addr, 32'h1004);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_hold_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("b2b_hold_ready", 32'(req_ready), 32'd0);
      chk("b2b_no_strobe", 32'(mem_memread), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_exit_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_exit_ready", 32'(req_ready), 32'd1);
    chk("b2b_not_yet", 32'(mem_memread), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_second_strobe", 32'(mem_memread), 32'd1);
    chk("b2b_second_addr", mem_addr, 32'h1008);
    n = 1;
    while (!rsp_valid && n < 12) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("b2b_second_rdata", rsp_rdata, ref_load(3'd2, 32'h1008));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset mid-transaction, then an immediate normal request.
    abort_txn(1);
    run_txn(1'b0, 3'd2, 32'h1004, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0111, 0);
    abort_txn(0);
    run_txn(1'b0, 3'd4, 32'h1003, 32'h0, 1'b0, 32'h00000080, 4'b0001, 1);

    // Random traffic against the reference model.
    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom);
      if ($urandom % 8 != 0) f3 = st ? 3'($urandom % 3) : ld_codes[$urandom % 5];
      else f3 = 3'($urandom);
      n = $urandom % 10;
      if (n < 7) begin
        a = BASE + 32'($urandom % BYTES);
        if ($urandom % 4 != 0) a = a & ~32'(acc_size(f3) - 1);
      end else if (n < 8) a = LED;
      else a = $urandom;
      wd = $urandom;
      e = ref_err(st, f3, a);
      rd = (e || st) ? 32'h0 : ref_load(f3, a);
      run_txn(st, f3, a, wd, e, rd, ref_mask(st, f3), int'($urandom % 3));
      if (st && !e) ref_store(f3, a, wd);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DMEM_BASE, default 32'h0000_1000, first byte address of data memory.
REQ-002 Parameter DMEM_BYTES, default 4096, size of data memory in bytes.
REQ-003 Parameter LED_ADDR, default 32'h0000_2000, memory-mapped LED register byte address.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  1  pipeline presents a load/store request.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_is_store  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 mem_addr  out  32  address to data memory.
REQ-013 mem_wdata  out  32  write data to data memory.
REQ-014 mem_memread  out  1  one-cycle read strobe to data memory.
REQ-015 mem_memwrite  out  1  one-cycle write strobe to data memory.
REQ-016 mem_sign_mask  out  4  {signed, word, half-or-word, 1} access encoding.
REQ-017 mem_read_data  in  32  registered load result from data memory.
REQ-018 rsp_valid  out  1  response available.
REQ-019 rsp_ready  in  1  pipeline consumes the response.
REQ-020 rsp_rdata  out  32  load result; 0 for stores and errors.
REQ-021 rsp_err  out  1  misaligned, illegal funct3, or out-of-range access.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT, LATCH, RESP; req_ready = 1 only in IDLE.
REQ-023 Accept occurs on an edge with req_valid & req_ready; the block latches is_store, funct3, addr and wdata; the latched values drive mem_addr/mem_wdata/mem_sign_mask, unchanged until return to IDLE.
REQ-024 mem_sign_mask: byte = 4'bx001, half = 4'bx011, word = 4'b0111; bit3 = 1 only for LB/LH.
REQ-025 Error on accept: load funct3 in {011,110,111}, store funct3 >= 011, half with addr[0] = 1, word with addr[1:0] != 0, address outside [DMEM_BASE, DMEM_BASE+DMEM_BYTES) other than LED_ADDR, or a load from LED_ADDR.
REQ-026 Error path: IDLE -> RESP with rsp_err = 1, rsp_rdata = 0; no mem strobe is ever asserted.
REQ-027 Good path: IDLE -> ISSUE -> WAIT -> LATCH -> RESP, one cycle per state except RESP.
REQ-028 mem_memread (loads) or mem_memwrite (stores) SHALL be high only in ISSUE, for exactly one cycle; both SHALL never be high together.
REQ-029 The LATCH-exit edge SHALL register rsp_rdata <= mem_read_data for loads and 0 for stores; rsp_err = 0.
REQ-030 Latency: rsp_valid SHALL rise 4 edges after the accept edge on the good path and 1 edge after it on the error path.
REQ-031 RESP: rsp_valid = 1 and rsp_rdata/rsp_err stable until an edge with rsp_ready = 1; then -> IDLE.
REQ-032 rsp_ready high in the first RESP cycle SHALL complete the response in one cycle.
REQ-033 Back-to-back: a new request is accepted no earlier than the cycle after the RESP-exit edge; throughput is at most 1 per 5 cycles.
REQ-034 req_* inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-035 A store to LED_ADDR SHALL follow the good path unchanged.

Reset
REQ-036 While rst_n = 0: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_memread = 0, mem_memwrite = 0, mem_addr = 0, mem_wdata = 0, mem_sign_mask = 0.
REQ-037 Reset asserted in any state SHALL abort the transaction at once, with no response issued; a strobe in flight drops asynchronously.
REQ-038 After rst_n deasserts, a request SHALL be accepted on the first rising edge.

Verification
REQ-039 LW addr 0x1004, memory word 0xDEADBEEF -> one-cycle memread with mask 0111; rsp_valid 4 edges after accept; rsp_rdata = 0xDEADBEEF; rsp_err = 0.
REQ-040 LB addr 0x1003, byte 0x80 -> mask 1001; rsp_rdata = 0xFFFFFF80. LBU same address -> mask 0001; rsp_rdata = 0x00000080.
REQ-041 SH addr 0x1001 -> rsp_err = 1 one edge after accept; no strobe. LW 0x3000 -> rsp_err = 1. Load funct3 011 -> rsp_err = 1.
REQ-042 SW 0x2000 data 0x000000A5 -> single memwrite cycle; led = 0xA5; rsp_rdata = 0.
REQ-043 Hold rsp_ready = 0 for 3 cycles in RESP -> rsp_valid/rsp_rdata stable; req_ready = 0; second req_valid held throughout is accepted only after the RESP-exit edge.
REQ-044 rst_n pulsed low during WAIT -> outputs reach reset values immediately; no rsp_valid; next request completes normally.
